// File: rtl/shifter_pipe_if.sv
// Request/response bundle for shifter_pipe: valid/ready request side carrying
// the operand and shift controls, valid/ready result side carrying y and flags.
interface shifter_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic [1:0]       sh;
  logic             rrx;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zero;

  modport slave (
    input  in_valid, a, shamt, sh, rrx, cin, out_ready,
    output in_ready, out_valid, y, cout, zero
  );

  modport master (
    output in_valid, a, shamt, sh, rrx, cin, out_ready,
    input  in_ready, out_valid, y, cout, zero
  );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage elastic barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out and zero flag.
// Stage 1 captures the request; stage 2 computes the shift and registers the result.
module shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  shifter_pipe_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("shifter_pipe: WIDTH must be 8, 16, 32 or 64");
  end

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_e;

  logic v1, v2, ld1, ld2;

  logic [WIDTH-1:0] a1;
  logic [SHW-1:0]   s1;
  sh_e              m1;
  logic             rrx1, cin1;

  logic [WIDTH-1:0] y_n, y_q;
  logic             cout_n, cout_q, zero_q;

  logic [WIDTH:0]     ext_l, ext_r, ext_a;
  logic [2*WIDTH-1:0] rot;

  assign ld2           = !v2 || bus.out_ready;
  assign ld1           = !v1 || ld2;
  assign bus.in_ready  = ld1;
  assign bus.out_valid = v2;
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ld1) v1 <= bus.in_valid;
      if (ld2) v2 <= v1;
    end
  end

  // NOTE: operand registers are qualified by v1, so they need no reset.
  always_ff @(posedge clk) begin
    if (ld1 && bus.in_valid) begin
      a1   <= bus.a;
      s1   <= bus.shamt;
      m1   <= sh_e'(bus.sh);
      rrx1 <= bus.rrx;
      cin1 <= bus.cin;
    end
  end

  // Extended shifts carry the last bit shifted out in the extra bit position.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    ext_l  = {1'b0, a1} << s1;
    ext_r  = {a1, 1'b0} >> s1;
    ext_a  = $signed({a1, 1'b0}) >>> s1;
    rot    = {a1, a1} >> s1;
    y_n    = a1;
    cout_n = cin1;
    if (s1 == '0) begin
      if (m1 == SH_ROR && rrx1) begin
        y_n    = {cin1, a1[WIDTH-1:1]};
        cout_n = a1[0];
      end
    end else begin
      unique case (m1)
        SH_LSL: begin
          y_n    = ext_l[WIDTH-1:0];
          cout_n = ext_l[WIDTH];
        end
        SH_LSR: begin
          y_n    = ext_r[WIDTH:1];
          cout_n = ext_r[0];
        end
        SH_ASR: begin
          y_n    = ext_a[WIDTH:1];
          cout_n = ext_a[0];
        end
        SH_ROR: begin
          y_n    = rot[WIDTH-1:0];
          cout_n = rot[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (ld2 && v1) begin
      y_q    <= y_n;
      cout_q <= cout_n;
      zero_q <= (y_n == '0);
    end
  end
endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64; other values SHALL fail elaboration.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width (5 at default).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready at a clock edge.
REQ-007 SHALL have port a, input, WIDTH, operand.
REQ-008 SHALL have port shamt, input, SHW, shift amount 0..WIDTH-1.
REQ-009 SHALL have port sh, input, 2, mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port rrx, input, 1, selects RRX when sh=11 and shamt=0; ignored otherwise.
REQ-011 SHALL have port cin, input, 1, incoming carry flag.
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready at a clock edge.
REQ-014 SHALL have port y, output, WIDTH, shifted result.
REQ-015 SHALL have port cout, output, 1, shifter carry-out.
REQ-016 SHALL have port zero, output, 1, high when y == 0.

Function
REQ-017 SHALL capture a, shamt, sh, rrx and cin on acceptance only; input changes at other times SHALL have no effect.
REQ-018 SHALL be a two-stage elastic pipeline with valid bits v1 and v2; the partition of shift logic between stages is free.
REQ-019 Stage-2 load enable SHALL be !v2 || out_ready; stage-1 load enable SHALL be !v1 || stage-2 load enable; in_ready SHALL equal stage-1 load enable.
REQ-020 Latency SHALL be exactly 2 cycles from acceptance to out_valid when the pipe is unstalled; throughput SHALL be 1 result/cycle with out_ready held high.
REQ-021 While out_valid && !out_ready, y, cout and zero SHALL hold stable.
REQ-022 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-023 LSL: y = a << shamt; cout = a[WIDTH-shamt] when shamt > 0.
REQ-024 LSR: y = a >> shamt with zero fill; cout = a[shamt-1] when shamt > 0.
REQ-025 ASR: y = a >> shamt with sign fill from a[WIDTH-1]; cout = a[shamt-1] when shamt > 0.
REQ-026 ROR: y = a rotated right by shamt; cout = y[WIDTH-1] when shamt > 0.
REQ-027 shamt = 0, no RRX (any mode): y = a and cout = cin.
REQ-028 RRX (sh=11, shamt=0, rrx=1): y = {cin, a[WIDTH-1:1]}; cout = a[0].
REQ-029 zero SHALL be computed from the final y of the same result.

Reset
REQ-030 rst_n low SHALL immediately clear v1 and v2, forcing out_valid = 0, y = 0, cout = 0 and zero = 0, independent of clk.
REQ-031 Operations in flight at reset SHALL be discarded and never emitted; in_ready SHALL be 1 during and after reset.
REQ-032 The first acceptance SHALL be possible on the first rising clk edge after rst_n rises.

Verification (WIDTH=32)
REQ-033 LSL a=0x80000001, shamt=1, cin=0 -> y=0x00000002, cout=1, zero=0; out_valid exactly 2 cycles after acceptance.
REQ-034 ASR a=0x80000000, shamt=31 -> y=0xFFFFFFFF, cout=0; LSR same operands -> y=0x00000001, cout=0.
REQ-035 ROR a=0x000000F1, shamt=4 -> y=0x1000000F, cout=0; RRX a=0x00000003, cin=1 -> y=0x80000001, cout=1.
REQ-036 LSR a=0x0000000F, shamt=4 -> y=0, zero=1, cout=1; LSL a=0x12345678, shamt=0, cin=1 -> y=0x12345678, cout=1.
REQ-037 Backpressure: out_ready=0, offer 3 back-to-back ops -> 2 accepted, in_ready=0 on the 3rd, y stable; raise out_ready -> all 3 delivered in order, one per cycle.
REQ-038 Reset mid-operation: both stages valid, pulse rst_n low between clk edges -> out_valid=0 at once, in_ready=1, no stale result after release.
